// File: rtl/mux2_tri_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux2_tri_pkg
// Purpose  : Shared constants for the mux2_tri tri-state 2:1 selector slice.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package mux2_tri_pkg;

  // Data width used by every file of the slice unless overridden.
  localparam int unsigned MUX2_TRI_DEFAULT_WIDTH = 4;

endpackage : mux2_tri_pkg
`default_nettype wire

// File: rtl/mux2_tri_if.sv
`default_nettype none
// ============================================================================
// Module   : mux2_tri_if
// Purpose  : Bundles the select-side signals of mux2_tri.
// Ports    : d0, d1 (WIDTH) data in; s select; y (WIDTH) combinational out;
//            y_q (WIDTH) registered out; y_valid registered-output qualifier.
//            master = producer/consumer side, slave = mux2_tri side.
// Revision : 1.0  initial release
// ============================================================================
interface mux2_tri_if
  import mux2_tri_pkg::*;
#(
  parameter int unsigned WIDTH = MUX2_TRI_DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             s;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             y_valid;

  modport master (
    output d0,
    output d1,
    output s,
    input  y,
    input  y_q,
    input  y_valid
  );

  modport slave (
    input  d0,
    input  d1,
    input  s,
    output y,
    output y_q,
    output y_valid
  );

endinterface : mux2_tri_if
`default_nettype wire

// File: rtl/tri_buf.sv
`default_nettype none
// ============================================================================
// Module   : tri_buf
// Purpose  : WIDTH-bit tri-state driver; releases its output when disabled.
// Ports    : a  (in, WIDTH) data to drive
//            en (in, 1)     drive enable
//            y  (out, WIDTH) a when en=1, high impedance otherwise
// Revision : 1.0  initial release
// ============================================================================
module tri_buf
  import mux2_tri_pkg::*;
#(
  parameter int unsigned WIDTH = MUX2_TRI_DEFAULT_WIDTH
) (
  input  wire logic [WIDTH-1:0] a,
  input  wire logic             en,
  output wire       [WIDTH-1:0] y
);

  assign y = en ? a : {WIDTH{1'bz}};

endmodule : tri_buf
`default_nettype wire

// File: rtl/mux2_tri.sv
`default_nettype none
// ============================================================================
// Module   : mux2_tri
// Purpose  : 2:1 data selector built from two tri-state drivers sharing one
//            internal bus, plus a registered copy of the selected value.
// Ports    : clk (in)  rising-edge clock for the registered path
//            rst (in)  synchronous active-high reset of y_q / y_valid
//            bus_if    slave modport: d0, d1, s in; y, y_q, y_valid out
// Revision : 1.0  initial release
// ============================================================================
module mux2_tri
  import mux2_tri_pkg::*;
#(
  parameter int unsigned WIDTH = MUX2_TRI_DEFAULT_WIDTH
) (
  input  wire logic   clk,
  input  wire logic   rst,
  mux2_tri_if.slave   bus_if
);

  // Shared bus: exactly one driver is enabled for any known select value,
  // because the two enables are strict complements.
  wire  [WIDTH-1:0] w_bus;
  logic             w_en0;
  logic             w_en1;

  logic [WIDTH-1:0] y_q_d;
  logic [WIDTH-1:0] y_q_q;
  logic             valid_d;
  logic             valid_q;

  assign w_en0 = ~bus_if.s;
  assign w_en1 =  bus_if.s;

  tri_buf #(.WIDTH(WIDTH)) u_buf0 (
    .a  (bus_if.d0),
    .en (w_en0),
    .y  (w_bus)
  );

  tri_buf #(.WIDTH(WIDTH)) u_buf1 (
    .a  (bus_if.d1),
    .en (w_en1),
    .y  (w_bus)
  );

  // Combinational output is the raw bus value: no clock or reset involvement.
  assign bus_if.y = w_bus;

  always_comb begin
    y_q_d   = w_bus;
    valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q_q   <= y_q_d;
      valid_q <= valid_d;
    end
  end

  assign bus_if.y_q     = y_q_q;
  assign bus_if.y_valid = valid_q;

endmodule : mux2_tri
`default_nettype wire

// File: tb/tb_mux2_tri.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux2_tri
// Purpose  : Self-checking bench for mux2_tri at WIDTH 4, 1 and 16.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_mux2_tri;

  logic        clk;
  logic        rst;
  logic [31:0] d0v;
  logic [31:0] d1v;
  logic        sv;

  int checks;
  int errors;

  // Reference state: what each registered output should hold now.
  logic [31:0] eq4;
  logic [31:0] eq1;
  logic [31:0] eq16;
  logic        ev;

  mux2_tri_if #(.WIDTH(4))  if4  ();
  mux2_tri_if #(.WIDTH(1))  if1  ();
  mux2_tri_if #(.WIDTH(16)) if16 ();

  assign if4.d0  = d0v[3:0];
  assign if4.d1  = d1v[3:0];
  assign if4.s   = sv;
  assign if1.d0  = d0v[0:0];
  assign if1.d1  = d1v[0:0];
  assign if1.s   = sv;
  assign if16.d0 = d0v[15:0];
  assign if16.d1 = d1v[15:0];
  assign if16.s  = sv;

  mux2_tri #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus_if(if4));
  mux2_tri #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus_if(if1));
  mux2_tri #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus_if(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selected value truncated to w bits.
  function automatic logic [31:0] mref(input logic [31:0] a, input logic [31:0] b,
                                       input logic sel, input int w);
    logic [31:0] mask;
    mask = (32'h1 << w) - 32'h1;
    return (sel ? b : a) & mask;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " y4"},   32'(if4.y),   mref(d0v, d1v, sv, 4));
    chk({tag, " y1"},   32'(if1.y),   mref(d0v, d1v, sv, 1));
    chk({tag, " y16"},  32'(if16.y),  mref(d0v, d1v, sv, 16));
    chk({tag, " yq4"},  32'(if4.y_q),  eq4);
    chk({tag, " yq1"},  32'(if1.y_q),  eq1);
    chk({tag, " yq16"}, 32'(if16.y_q), eq16);
    chk({tag, " valid"}, {31'd0, if4.y_valid & if1.y_valid & if16.y_valid}, {31'd0, ev});
    chk({tag, " valid_any"}, {31'd0, if4.y_valid | if1.y_valid | if16.y_valid}, {31'd0, ev});
  endtask

  // Advance one clock; update the reference from the values present at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      eq4 = '0; eq1 = '0; eq16 = '0; ev = 1'b0;
    end else begin
      eq4  = mref(d0v, d1v, sv, 4);
      eq1  = mref(d0v, d1v, sv, 1);
      eq16 = mref(d0v, d1v, sv, 16);
      ev   = 1'b1;
    end
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sel);
    d0v = a;
    d1v = b;
    sv  = sel;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    eq4 = '0; eq1 = '0; eq16 = '0; ev = 1'b0;
    rst = 1'b1;
    d0v = '0; d1v = '0; sv = 1'b0;

    // Reset state
    tick();
    tick();
    check_all("reset");
    rst = 1'b0;

    // 1: s=0 selects d0
    drive(32'hA, 32'h5, 1'b0);
    check_all("t1 comb");
    tick();
    check_all("t1 reg");

    // 2: switch select with data held
    drive(32'hA, 32'h5, 1'b1);
    check_all("t2 comb");
    tick();
    check_all("t2 reg");

    // 3: d0 change visible, d1 change ignored while s=0
    drive(32'hC, 32'h5, 1'b0);
    check_all("t3 comb");
    drive(32'hC, 32'hF, 1'b0);
    check_all("t3 d1chg");
    tick();
    check_all("t3 reg");

    // 4: s=1 with new d1 in the same timestep
    drive(32'hC, 32'h3, 1'b1);
    check_all("t4 comb");
    tick();
    check_all("t4 reg");

    // 5: reset mid-operation while toggling s
    rst = 1'b1;
    drive(32'h9, 32'h6, 1'b0);
    check_all("t5 pre");
    tick();
    check_all("t5 rst1");
    drive(32'h9, 32'h6, 1'b1);
    check_all("t5 tog");
    tick();
    check_all("t5 rst2");
    rst = 1'b0;
    drive(32'h9, 32'h6, 1'b0);
    tick();
    check_all("t5 release");

    // 6: random sweep with occasional reset
    for (int i = 0; i < 1000; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      drive($urandom, $urandom, 1'($urandom_range(0, 1)));
      check_all("sweep comb");
      tick();
      check_all("sweep reg");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux2_tri
`default_nettype wire
